aes_core_ctrl: RTL and testbench

Request scheduler placed in front of the iterative AES engine (enciphering/deciphering datapath plus the shared key generator and S-box). It accepts one 128-bit block job at a time over a valid/ready handshake and caches the last expanded key, re-running key expansion only when the key changes. It then sequences the engine's `init`/`ready` protocol, with a watchdog, and returns the result over a second valid/ready handshake with an error flag.

---
 rtl/aes_pkg.sv | 31 +++
 rtl/aes_core_ctrl_if.sv | 26 ++
 rtl/aes_key_cache.sv | 32 +++
 rtl/aes_core_ctrl.sv | 176 +++++++++++++++++
 tb/tb_aes_core_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared types and constants for the AES request scheduler.
// State codes are 3-bit; the watchdog limit defaults to its 8-bit maximum.
package aes_pkg;

    localparam int BLK_W        = 128;
    localparam int TIMEOUT_DFLT = 255;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_KEY_INIT = 3'd1;
    localparam logic [2:0] S_KEY_WAIT = 3'd2;
    localparam logic [2:0] S_ENG_INIT = 3'd3;
    localparam logic [2:0] S_ENG_LOW  = 3'd4;
    localparam logic [2:0] S_ENG_HIGH = 3'd5;
    localparam logic [2:0] S_RESP     = 3'd6;

    typedef enum logic [2:0] {
        IDLE     = S_IDLE,
        KEY_INIT = S_KEY_INIT,
        KEY_WAIT = S_KEY_WAIT,
        ENG_INIT = S_ENG_INIT,
        ENG_LOW  = S_ENG_LOW,
        ENG_HIGH = S_ENG_HIGH,
        RESP     = S_RESP
    } state_t;

    // States in which the watchdog runs.
    function automatic logic is_wait(state_t s);
        return (s == KEY_WAIT) || (s == ENG_LOW) || (s == ENG_HIGH);
    endfunction

endpackage

// File: rtl/aes_core_ctrl_if.sv
// aes_core_ctrl_if: job request and result handshakes of the scheduler.
// master = job source / result sink, slave = the scheduler.
interface aes_core_ctrl_if;
    import aes_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_encdec;
    logic [BLK_W-1:0] req_key;
    logic [BLK_W-1:0] req_block;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [BLK_W-1:0] rsp_data;
    logic             rsp_error;

    modport master (
        output req_valid, req_encdec, req_key, req_block, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_encdec, req_key, req_block, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error
    );

endinterface

// File: rtl/aes_key_cache.sv
// aes_key_cache: remembers the last expanded key and flags a repeat.
// Mode is not part of the tag; both directions share one schedule.
module aes_key_cache
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [BLK_W-1:0] load_key,
    input  logic [BLK_W-1:0] cmp_key,
    output logic             hit
);

    logic             key_vld;
    logic [BLK_W-1:0] key_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_vld <= 1'b0;
            key_reg <= '0;
        end else if (clr) begin
            key_vld <= 1'b0;
        end else if (load) begin
            key_vld <= 1'b1;
            key_reg <= load_key;
        end
    end

    assign hit = key_vld && (cmp_key == key_reg);

endmodule

// File: rtl/aes_core_ctrl.sv
// aes_core_ctrl: one-job-at-a-time scheduler for the iterative AES engine.
// Skips key expansion on a key hit and aborts any stalled wait via watchdog.
module aes_core_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DFLT
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_core_ctrl_if.slave       bus,
    output logic                 key_init,
    input  logic                 key_ready,
    output logic                 eng_init,
    output logic                 eng_encdec,
    output logic [BLK_W-1:0]     eng_key,
    output logic [BLK_W-1:0]     eng_block,
    input  logic [BLK_W-1:0]     eng_result,
    input  logic                 eng_ready,
    output logic                 busy,
    output logic [15:0]          blk_cnt
);

    localparam logic [7:0] WD_MAX = 8'(TIMEOUT);

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       wd_cnt;
    logic             wd_hit;
    logic             accept;
    logic             done;
    logic             abort;
    logic             kc_clr;
    logic             kc_load;
    logic             kc_hit;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic             rsp_error_q;
    logic [BLK_W-1:0] rsp_data_q;

    aes_key_cache u_key_cache (
        .clk      (clk),
        .reset    (reset),
        .clr      (kc_clr),
        .load     (kc_load),
        .load_key (eng_key),
        .cmp_key  (bus.req_key),
        .hit      (kc_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        kc_clr    = 1'b0;
        kc_load   = 1'b0;
        wd_hit    = (wd_cnt == WD_MAX);
        unique case (state)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    accept    = 1'b1;
                    state_nxt = kc_hit ? ENG_INIT : KEY_INIT;
                end
            end
            KEY_INIT: begin
                kc_clr    = 1'b1;
                state_nxt = KEY_WAIT;
            end
            KEY_WAIT: begin
                if (key_ready) begin
                    kc_load   = 1'b1;
                    state_nxt = ENG_INIT;
                end else if (wd_hit) begin
                    abort = 1'b1;
                end
            end
            ENG_INIT: begin
                state_nxt = ENG_LOW;
            end
            ENG_LOW: begin
                if (!eng_ready) begin
                    state_nxt = ENG_HIGH;
                end else if (wd_hit) begin
                    abort = 1'b1;
                end
            end
            ENG_HIGH: begin
                if (eng_ready) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end else if (wd_hit) begin
                    abort = 1'b1;
                end
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A timed-out job cannot trust the key generator state either.
        if (abort) begin
            state_nxt = RESP;
            kc_clr    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if ((state_nxt != state) && is_wait(state_nxt)) begin
            wd_cnt <= '0;
        end else if (is_wait(state)) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            key_init    <= 1'b0;
            eng_init    <= 1'b0;
        end else begin
            req_ready_q <= (state_nxt == IDLE);
            rsp_valid_q <= (state_nxt == RESP);
            key_init    <= (state_nxt == KEY_INIT);
            eng_init    <= (state_nxt == ENG_INIT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_encdec <= 1'b0;
            eng_key    <= '0;
            eng_block  <= '0;
        end else if (accept) begin
            eng_encdec <= bus.req_encdec;
            eng_key    <= bus.req_key;
            eng_block  <= bus.req_block;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            blk_cnt     <= '0;
        end else if (done) begin
            rsp_data_q  <= eng_result;
            rsp_error_q <= 1'b0;
            blk_cnt     <= blk_cnt + 16'd1;
        end else if (abort) begin
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b1;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_error = rsp_error_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_aes_core_ctrl.sv
// tb_aes_core_ctrl: scoreboard bench with key-generator and engine models.
// Expected responses come from a job-level model of caching and timeouts.
`timescale 1ns/1ps
module tb_aes_core_ctrl;
    import aes_pkg::*;

    localparam int TO = 60;
    localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K3 = 128'hdeadbeef0123456789abcdeffedcba98;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_core_ctrl_if bus ();
    logic         key_init, key_ready, eng_init, eng_encdec, eng_ready, busy;
    logic [127:0] eng_key, eng_block, eng_result;
    logic [15:0]  blk_cnt;

    aes_core_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(rst_n), .bus(bus),
        .key_init(key_init), .key_ready(key_ready),
        .eng_init(eng_init), .eng_encdec(eng_encdec),
        .eng_key(eng_key), .eng_block(eng_block),
        .eng_result(eng_result), .eng_ready(eng_ready),
        .busy(busy), .blk_cnt(blk_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    // Stand-in cipher: real FIPS-197 pair for the known vector, else a rotation mix.
    function automatic logic [127:0] mock(input bit enc, input logic [127:0] k, input logic [127:0] b);
        logic [127:0] t;
        if (k == FK && enc && b == PT) return CT;
        if (k == FK && !enc && b == CT) return PT;
        if (enc) return {b[120:0], b[127:121]} ^ k;
        t = b ^ k;
        return {t[6:0], t[127:7]};
    endfunction

    // Key generator and engine models; latencies set per job by the driver.
    int kl_cfg = 1;
    int el_cfg = 1;
    int kcnt, ecnt;
    logic [127:0] eres;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_ready <= 1'b1;
            kcnt <= 0;
        end else if (key_init) begin
            if (kl_cfg > 0) begin
                key_ready <= 1'b0;
                kcnt <= kl_cfg;
            end
        end else if (kcnt > 0) begin
            kcnt <= kcnt - 1;
            if (kcnt == 1) key_ready <= 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_ready <= 1'b1;
            ecnt <= 0;
            eng_result <= '0;
            eres <= '0;
        end else if (eng_init) begin
            eng_ready <= 1'b0;
            ecnt <= el_cfg;
            eres <= mock(eng_encdec, eng_key, eng_block);
            eng_result <= {$urandom, $urandom, $urandom, $urandom};
        end else if (ecnt > 0) begin
            ecnt <= ecnt - 1;
            if (ecnt == 1) begin
                eng_ready <= 1'b1;
                eng_result <= eres;
            end
        end
    end

    typedef struct {
        logic [127:0] data;
        bit           err;
        logic [15:0]  cnt;
        int           nk;
        int           ne;
        int           eoff;
        int           roff;
    } exp_t;

    exp_t exp_q[$];

    // Monitor: job-relative cycle offsets, pulse counts, response compare.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int acc = 0;
    int nk = 0, ne = 0, eoff = -1;
    bit prev_rdy = 0, prev_rv = 0;
    logic [127:0] hold_data;
    logic hold_err;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_rdy = 0;
            prev_rv = 0;
            nk = 0;
            ne = 0;
            eoff = -1;
        end else begin
            if (prev_rdy && !bus.req_ready) begin
                acc = cyc - 1;
                nk = 0;
                ne = 0;
                eoff = -1;
            end
            if (key_init) nk++;
            if (eng_init) begin
                ne++;
                eoff = cyc - acc;
            end
            if (bus.rsp_valid && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp data %h", bus.rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_error", 128'(bus.rsp_error), 128'(e.err));
                    chk("blk_cnt", 128'(blk_cnt), 128'(e.cnt));
                    chk("n_key_init", 128'(nk), 128'(e.nk));
                    chk("n_eng_init", 128'(ne), 128'(e.ne));
                    chk("eng_init_cycle", 128'(eoff), 128'(e.eoff));
                    chk("rsp_cycle", 128'(cyc - acc), 128'(e.roff));
                    chk("busy_in_rsp", 128'(busy), 128'd1);
                end
            end else if (bus.rsp_valid) begin
                chk("rsp_data_stable", bus.rsp_data, hold_data);
                chk("rsp_error_stable", 128'(bus.rsp_error), 128'(hold_err));
                chk("stall_quiet", {125'd0, bus.req_ready, eng_init, key_init}, 128'd0);
            end
            prev_rdy = bus.req_ready;
            prev_rv = bus.rsp_valid;
            hold_data = bus.rsp_data;
            hold_err = bus.rsp_error;
        end
    end

    // Job-level reference state.
    bit           c_vld = 0;
    logic [127:0] c_key = '0;
    logic [15:0]  m_cnt = '0;

    task automatic die(input string n);
        errors++;
        $display("FAIL %s timed out", n);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench aborted");
    endtask

    task automatic send(input bit enc, input logic [127:0] k, input logic [127:0] b);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_encdec = enc;
        bus.req_key = k;
        bus.req_block = b;
        for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
        if (!bus.req_ready) die("req_ready");
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_encdec = ~enc;
        bus.req_key = {$urandom, $urandom, $urandom, $urandom};
        bus.req_block = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic job(input bit enc, input logic [127:0] k, input logic [127:0] b,
                       input int kl, input int el, input int stall);
        exp_t e;
        bit hit;
        int ec;
        hit = c_vld && (k == c_key);
        e.nk = hit ? 0 : 1;
        ec = hit ? 1 : kl + 3;
        if (!hit && kl > TO) begin
            e.err = 1;
            e.ne = 0;
            e.eoff = -1;
            e.roff = TO + 3;
            c_vld = 0;
        end else begin
            c_key = k;
            c_vld = 1;
            e.ne = 1;
            e.eoff = ec;
            if (el <= TO + 1) begin
                e.err = 0;
                e.roff = ec + el + 2;
            end else begin
                e.err = 1;
                e.roff = ec + TO + 3;
                c_vld = 0;
            end
        end
        if (e.err) begin
            e.data = '0;
        end else begin
            e.data = mock(enc, k, b);
            m_cnt = m_cnt + 16'd1;
        end
        e.cnt = m_cnt;
        exp_q.push_back(e);
        kl_cfg = kl;
        el_cfg = el;
        send(enc, k, b);
        for (int i = 0; i < 3000 && !bus.rsp_valid; i++) @(negedge clk);
        if (!bus.rsp_valid) die("rsp_valid");
        repeat (stall) @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_rsp", {126'd0, bus.req_ready, busy}, 128'd2);
    endtask

    task automatic chk_reset(input string n);
        chk({n, "_ctl"}, {121'd0, bus.req_ready, bus.rsp_valid, bus.rsp_error,
            key_init, eng_init, eng_encdec, busy}, 128'd0);
        chk({n, "_rsp_data"}, bus.rsp_data, 128'd0);
        chk({n, "_eng_kb"}, eng_key | eng_block, 128'd0);
        chk({n, "_blk_cnt"}, 128'(blk_cnt), 128'd0);
    endtask

    initial begin
        #2000000;
        die("global");
    end

    initial begin
        logic [127:0] pool [3];
        logic [127:0] k, b;
        int el;
        pool[0] = FK;
        pool[1] = K2;
        pool[2] = K3;
        bus.req_valid = 1'b0;
        bus.req_encdec = 1'b0;
        bus.req_key = '0;
        bus.req_block = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {126'd0, bus.req_ready, busy}, 128'd2);

        job(1, FK, PT, 10, 40, 0);
        job(0, FK, CT, 10, 40, 1);
        job(1, K2, PT, 5, 40, 0);
        job(1, K2, PT, 5, 100000, 0);
        job(0, K2, CT, 3, 10, 2);
        job(1, K2, 128'h0123456789abcdef0011223344556677, 0, TO + 1, 0);
        job(1, FK, PT, TO, 5, 0);
        job(0, FK, CT, 0, TO + 2, 0);
        job(1, K2, PT, TO + 1, 5, 0);
        job(0, K2, 128'hcafef00d, 0, 3, 100);

        for (int n = 0; n < 40; n++) begin
            k = pool[$urandom_range(0, 2)];
            b = {$urandom, $urandom, $urandom, $urandom};
            el = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(1, 45);
            job($urandom_range(0, 1) == 1, k, b, $urandom_range(0, 8), el,
                $urandom_range(0, 3));
        end

        job(1, FK, PT, 2, 20, 0);
        kl_cfg = 2;
        el_cfg = 1000;
        send(1, FK, PT);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midjob_reset");
        c_vld = 0;
        m_cnt = '0;
        @(negedge clk);
        chk_reset("midjob_reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_midjob", {126'd0, bus.req_ready, busy}, 128'd2);
        job(1, FK, PT, 2, 20, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
